// File: rtl/campo_bcd_config.sv
// campo_bcd_config
//   Two-digit BCD field counter for the clock/calendar setting path. The value
//   wraps within [MIN_VAL..MAX_VAL]. It is edited by up/down buttons, with
//   hold-to-repeat, while sel == FIELD_ID. Otherwise it advances on a run-mode
//   tick. Carry and borrow pulses let several fields be cascaded.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   sel       in   [3:0] field-select bus; edit enabled when sel == FIELD_ID
//   up        in   increment button (debounced, synchronous)
//   down      in   decrement button (debounced, synchronous)
//   tick      in   1-cycle run-mode advance pulse
//   load      in   1-cycle parallel load strobe
//   load_val  in   [7:0] BCD load value {tens,ones}
//   bcd_out   out  [7:0] current value {tens,ones}
//   carry     out  1-cycle pulse when a tick wraps MAX_VAL->MIN_VAL
//   borrow    out  1-cycle pulse when a manual down step wraps MIN_VAL->MAX_VAL
//   load_err  out  1-cycle pulse when a load is rejected
module campo_bcd_config #(
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 59,
    parameter int unsigned FIELD_ID   = 2,
    parameter int unsigned REPEAT_DLY = 50_000_000,
    parameter int unsigned REPEAT_PER = 13_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sel,
    input  logic       up,
    input  logic       down,
    input  logic       tick,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] bcd_out,
    output logic       carry,
    output logic       borrow,
    output logic       load_err
);

    localparam int unsigned TimerMax = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    localparam logic [TimerW-1:0] DlyLast = TimerW'(REPEAT_DLY - 1);
    localparam logic [TimerW-1:0] PerLast = TimerW'(REPEAT_PER - 1);

    localparam logic [7:0] MinBcd = {4'(MIN_VAL / 10), 4'(MIN_VAL % 10)};
    localparam logic [7:0] MaxBcd = {4'(MAX_VAL / 10), 4'(MAX_VAL % 10)};
    localparam logic [7:0] MinBin = 8'(MIN_VAL);
    localparam logic [7:0] MaxBin = 8'(MAX_VAL);

    typedef enum logic [1:0] {StIdle, StWait, StRepeat} state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic              dir_q, dir_d;       // 1 = up, direction of the press being held
    logic [3:0]        tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic              carry_q, carry_d;
    logic              borrow_q, borrow_d;
    logic              load_err_q, load_err_d;

    logic       edit;
    logic       btn;
    logic       step;
    logic       step_up;
    logic       at_max;
    logic       at_min;
    logic [7:0] inc_val;
    logic [7:0] dec_val;
    logic [7:0] lv_bin;
    logic       load_ok;

    assign edit   = (sel == 4'(FIELD_ID));
    assign btn    = edit & (up ^ down);
    assign at_max = ({tens_q, ones_q} == MaxBcd);
    assign at_min = ({tens_q, ones_q} == MinBcd);

    // BCD successor / predecessor with range wrap.
    always_comb begin
        inc_val = {tens_q, ones_q};
        if (at_max) begin
            inc_val = MinBcd;
        end else if (ones_q == 4'd9) begin
            inc_val = {tens_q + 4'd1, 4'd0};
        end else begin
            inc_val = {tens_q, ones_q + 4'd1};
        end
    end

    always_comb begin
        dec_val = {tens_q, ones_q};
        if (at_min) begin
            dec_val = MaxBcd;
        end else if (ones_q == 4'd0) begin
            dec_val = {tens_q - 4'd1, 4'd9};
        end else begin
            dec_val = {tens_q, ones_q - 4'd1};
        end
    end

    // Load check. lv_bin is only meaningful when both digits are valid; the +1
    // form keeps the lower-bound compare well-defined for MIN_VAL == 0.
    assign lv_bin  = 8'(load_val[7:4]) * 8'd10 + 8'(load_val[3:0]);
    assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                     ((lv_bin + 8'd1) > MinBin) && (lv_bin <= MaxBin);

    // Hold FSM: first step on press, then REPEAT_DLY delay, then every REPEAT_PER.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        dir_d   = dir_q;
        step    = 1'b0;
        step_up = dir_q;
        unique case (state_q)
            StIdle: begin
                if (btn) begin
                    step    = 1'b1;
                    step_up = up;
                    dir_d   = up;
                    timer_d = '0;
                    state_d = StWait;
                end
            end
            StWait, StRepeat: begin
                // Release or reversal ends the press without a step.
                if (!btn || (up != dir_q)) begin
                    timer_d = '0;
                    state_d = StIdle;
                end else if (timer_q == ((state_q == StWait) ? DlyLast : PerLast)) begin
                    step    = 1'b1;
                    timer_d = '0;
                    state_d = StRepeat;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                timer_d = '0;
                state_d = StIdle;
            end
        endcase

        // A load overrides everything and restarts the press handling.
        if (load) begin
            timer_d = '0;
            state_d = StIdle;
        end
    end

    // Value path, priority load > manual step > tick.
    always_comb begin
        tens_d     = tens_q;
        ones_d     = ones_q;
        carry_d    = 1'b0;
        borrow_d   = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                {tens_d, ones_d} = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (step) begin
            if (step_up) begin
                {tens_d, ones_d} = inc_val;
            end else begin
                {tens_d, ones_d} = dec_val;
                borrow_d         = at_min;
            end
        end else if (tick && !edit) begin
            {tens_d, ones_d} = inc_val;
            carry_d          = at_max;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            dir_q      <= 1'b0;
            tens_q     <= MinBcd[7:4];
            ones_q     <= MinBcd[3:0];
            carry_q    <= 1'b0;
            borrow_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dir_q      <= dir_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            carry_q    <= carry_d;
            borrow_q   <= borrow_d;
            load_err_q <= load_err_d;
        end
    end

    assign bcd_out  = {tens_q, ones_q};
    assign carry    = carry_q;
    assign borrow   = borrow_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_campo_bcd_config.sv
module tb_campo_bcd_config;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sel;
    logic       up, down, tick, load;
    logic [7:0] load_val;

    logic [7:0] bcd_a, bcd_b;
    logic       carry_a, borrow_a, err_a;
    logic       carry_b, borrow_b, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Default field 0..59
    campo_bcd_config #(
        .MIN_VAL(0), .MAX_VAL(59), .FIELD_ID(2), .REPEAT_DLY(8), .REPEAT_PER(4)
    ) dut (
        .clk(clk), .reset(reset), .sel(sel), .up(up), .down(down), .tick(tick),
        .load(load), .load_val(load_val), .bcd_out(bcd_a), .carry(carry_a),
        .borrow(borrow_a), .load_err(err_a)
    );

    // Month-like field 1..12 sharing the same stimulus
    campo_bcd_config #(
        .MIN_VAL(1), .MAX_VAL(12), .FIELD_ID(2), .REPEAT_DLY(8), .REPEAT_PER(4)
    ) dut_b (
        .clk(clk), .reset(reset), .sel(sel), .up(up), .down(down), .tick(tick),
        .load(load), .load_val(load_val), .bcd_out(bcd_b), .carry(carry_b),
        .borrow(borrow_b), .load_err(err_b)
    );

    typedef struct {
        logic [3:0] sel;
        logic       up;
        logic       down;
        logic       tick;
        logic       load;
        logic [7:0] lv;
        logic [7:0] exp_bcd;
        logic       exp_carry;
        logic       exp_borrow;
        logic       exp_err;
    } vec_t;

    vec_t vecs[24];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s, input logic u, input logic d, input logic t,
                         input logic l, input logic [7:0] v);
        sel = s; up = u; down = d; tick = t; load = l; load_val = v;
    endtask

    function automatic vec_t mk(input logic [3:0] s, input logic u, input logic d,
                                input logic t, input logic l, input logic [7:0] v,
                                input logic [7:0] eb, input logic ec, input logic ebr,
                                input logic ee);
        vec_t r;
        r.sel = s; r.up = u; r.down = d; r.tick = t; r.load = l; r.lv = v;
        r.exp_bcd = eb; r.exp_carry = ec; r.exp_borrow = ebr; r.exp_err = ee;
        return r;
    endfunction

    // Expected count after k cycles of holding up from zero (DLY=8, PER=4).
    function automatic int hold_steps(input int k);
        if (k < 8) return 1;
        return 2 + (k - 8) / 4;
    endfunction

    initial begin
        //              sel  u  d  t  l  lv      bcd    c  b  e
        vecs[0]  = mk(4'd2, 1, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
        vecs[1]  = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h01, 0, 0, 0);
        vecs[2]  = mk(4'd2, 0, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[3]  = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[4]  = mk(4'd2, 0, 1, 0, 0, 8'h00, 8'h59, 0, 1, 0);
        vecs[5]  = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h59, 0, 0, 0);
        vecs[6]  = mk(4'd2, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[7]  = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[8]  = mk(4'd2, 0, 1, 0, 0, 8'h00, 8'h59, 0, 1, 0);
        vecs[9]  = mk(4'd0, 0, 0, 1, 0, 8'h00, 8'h00, 1, 0, 0);
        vecs[10] = mk(4'd0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        vecs[11] = mk(4'd0, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0);
        vecs[12] = mk(4'd2, 0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 0);
        vecs[13] = mk(4'd0, 0, 0, 0, 1, 8'h45, 8'h45, 0, 0, 0);
        vecs[14] = mk(4'd0, 0, 0, 1, 1, 8'h60, 8'h45, 0, 0, 1);
        vecs[15] = mk(4'd0, 0, 0, 0, 1, 8'h3A, 8'h45, 0, 0, 1);
        vecs[16] = mk(4'd0, 0, 0, 0, 0, 8'h00, 8'h45, 0, 0, 0);
        vecs[17] = mk(4'd2, 1, 0, 0, 1, 8'h20, 8'h20, 0, 0, 0);
        vecs[18] = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h20, 0, 0, 0);
        vecs[19] = mk(4'd2, 1, 1, 0, 0, 8'h00, 8'h20, 0, 0, 0);
        vecs[20] = mk(4'd0, 0, 0, 0, 1, 8'h09, 8'h09, 0, 0, 0);
        vecs[21] = mk(4'd0, 0, 0, 1, 0, 8'h00, 8'h10, 0, 0, 0);
        vecs[22] = mk(4'd2, 0, 1, 0, 0, 8'h00, 8'h09, 0, 0, 0);
        vecs[23] = mk(4'd2, 0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 0);

        reset = 1'b1;
        drive(4'd0, 0, 0, 0, 0, 8'h00);
        cyc();
        cyc();
        chk("reset bcd_a", bcd_a, 8'h00);
        chk("reset bcd_b", bcd_b, 8'h01);
        chk("reset pulses", {5'd0, carry_a, borrow_a, err_a}, 8'h00);
        reset = 1'b0;

        // Table-driven single-cycle vectors on the 0..59 field
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].sel, vecs[i].up, vecs[i].down, vecs[i].tick, vecs[i].load,
                  vecs[i].lv);
            cyc();
            chk($sformatf("vec%0d bcd", i), bcd_a, vecs[i].exp_bcd);
            chk($sformatf("vec%0d flags", i), {5'd0, carry_a, borrow_a, err_a},
                {5'd0, vecs[i].exp_carry, vecs[i].exp_borrow, vecs[i].exp_err});
        end

        // Hold-to-repeat from 00 for 30 cycles
        drive(4'd0, 0, 0, 0, 1, 8'h00);
        cyc();
        for (int k = 0; k < 30; k++) begin
            drive(4'd2, 1, 0, 0, 0, 8'h00);
            cyc();
            chk($sformatf("hold k%0d", k), bcd_a, 8'(hold_steps(k)));
        end
        drive(4'd2, 0, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) cyc();
        chk("hold release", bcd_a, 8'h07);

        // up+down together, then sel leaving mid-hold
        drive(4'd2, 0, 0, 0, 1, 8'h00);
        cyc();
        drive(4'd2, 1, 1, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) cyc();
        chk("up+down", bcd_a, 8'h00);
        for (int k = 0; k < 10; k++) begin
            drive((k < 5) ? 4'd2 : 4'd3, 1, 0, 0, 0, 8'h00);
            cyc();
        end
        chk("sel leave", bcd_a, 8'h01);
        drive(4'd3, 0, 0, 0, 0, 8'h00);
        cyc();

        // Async reset in REPEAT at 33
        drive(4'd0, 0, 0, 0, 1, 8'h30);
        cyc();
        for (int k = 0; k < 13; k++) begin
            drive(4'd2, 1, 0, 0, 0, 8'h00);
            cyc();
        end
        chk("pre-reset 33", bcd_a, 8'h33);
        reset = 1'b1;
        #1;
        chk("async reset", bcd_a, 8'h00);
        cyc();
        reset = 1'b0;
        cyc();
        chk("post-reset press", bcd_a, 8'h01);
        cyc();
        chk("post-reset wait", bcd_a, 8'h01);
        drive(4'd0, 0, 0, 0, 0, 8'h00);
        cyc();

        // Load validation on the 1..12 field
        drive(4'd0, 0, 0, 0, 1, 8'h12);
        cyc();
        chk("b load 12", bcd_b, 8'h12);
        chk("b load 12 err", {7'd0, err_b}, 8'h00);
        drive(4'd0, 0, 0, 0, 1, 8'h13);
        cyc();
        chk("b load 13", bcd_b, 8'h12);
        chk("b load 13 err", {7'd0, err_b}, 8'h01);
        drive(4'd0, 0, 0, 0, 1, 8'h00);
        cyc();
        chk("b load 00", bcd_b, 8'h12);
        chk("b load 00 err", {7'd0, err_b}, 8'h01);
        drive(4'd0, 0, 0, 0, 1, 8'h1A);
        cyc();
        chk("b load 1A", bcd_b, 8'h12);
        chk("b load 1A err", {7'd0, err_b}, 8'h01);
        drive(4'd0, 0, 0, 0, 0, 8'h00);
        cyc();
        chk("b err clear", {7'd0, err_b}, 8'h00);
        drive(4'd2, 1, 0, 0, 0, 8'h00);
        cyc();
        chk("b up wrap", bcd_b, 8'h01);
        chk("b up wrap flags", {6'd0, carry_b, borrow_b}, 8'h00);
        drive(4'd2, 0, 0, 0, 0, 8'h00);
        cyc();
        drive(4'd2, 0, 1, 0, 0, 8'h00);
        cyc();
        chk("b down wrap", bcd_b, 8'h12);
        chk("b borrow", {7'd0, borrow_b}, 8'h01);
        drive(4'd0, 0, 0, 0, 0, 8'h00);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
